bk_add_sched: RTL
=================

BK_ADD_SCHED -- requirements
Module: bk_add_sched

Interface
REQ-001 SHALL use parameters: NREQ, default 4, requester count; W, default 24, operand width (two 12-bit beats).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, NREQ, per-requester request valid.
REQ-005 SHALL have port req_ready, output, NREQ, one-hot accept pulse.
REQ-006 SHALL have port req_a, input, NREQ*W, operand A per requester; slice i = bits [i*W +: W].
REQ-007 SHALL have port req_b, input, NREQ*W, operand B per requester; same slicing as req_a.
REQ-008 SHALL have port add_in, output, 24, interleaved operands to the shared 12-bit Brent-Kung adder; add_in[2k] = a[k], add_in[2k+1] = b[k].
REQ-009 SHALL have port add_out, input, 13, adder result; [11:0] = sum, [12] = carry-out.
REQ-010 SHALL have port resp_valid, output, 1, result available.
REQ-011 SHALL have port resp_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port resp_id, output, log2(NREQ), index of the served requester.
REQ-013 SHALL have port resp_sum, output, W+1, full sum; the MSB is the carry.

Function
REQ-014 SHALL implement states IDLE, LO, HI, INC, DONE.
REQ-015 IDLE: when any req_valid is high, SHALL assert req_ready[g] for one cycle, latch a, b and g, and go to LO.
REQ-016 SHALL choose g by round-robin starting at the pointer; the pointer SHALL become (g+1) mod NREQ on grant.
REQ-017 LO: SHALL drive add_in from a[11:0] and b[11:0], register sum_lo = add_out[11:0] and c0 = add_out[12], and go to HI.
REQ-018 HI: SHALL drive add_in from a[23:12] and b[23:12], register sum_hi and c1, then go to INC if c0 = 1, else to DONE.
REQ-019 INC: SHALL drive add_in with a = sum_hi and b = 12'h001, overwrite sum_hi with add_out[11:0], set c1 = c1 | add_out[12], and go to DONE.
REQ-020 DONE: SHALL hold resp_valid = 1 and resp_sum = {c1, sum_hi, sum_lo} stable until resp_valid & resp_ready, then go to IDLE.
REQ-021 A new grant SHALL occur no earlier than the cycle after the response handshake; at most one operation is in flight.
REQ-022 Latency from grant cycle T to first resp_valid SHALL be T+3 (no INC) or T+4 (INC).
REQ-023 add_in SHALL be 0 in IDLE and DONE.
REQ-024 req_ready SHALL be zero outside the IDLE grant cycle; req_valid of ungranted requesters SHALL have no effect.
REQ-025 If a requester drops req_valid before being granted, the block SHALL NOT serve it; no request is remembered.

Reset
REQ-026 On rst_n low, state SHALL go to IDLE immediately, including mid-operation; the in-flight operation is discarded with no response.
REQ-027 Reset values SHALL be: req_ready = 0, resp_valid = 0, resp_id = 0, resp_sum = 0, add_in = 0, pointer = 0.

Structure
REQ-028 A shared package bk_sched_pkg SHALL hold the state enum, BEAT_W = 12, ADD_IN_W = 24 and ADD_OUT_W = 13.
REQ-029 The round-robin grant logic SHALL be a sub-module rr_arb (request vector, pointer -> one-hot grant and index).
REQ-030 The adder SHALL stay external; bk_add_sched contains no adder.

Verification
REQ-031 Bench SHALL model the adder combinationally and cover the following scenarios.
REQ-032 req0: a=0x000FFF, b=0x000001 -> INC path taken, resp_sum=0x0001000, resp_id=0, resp_valid at T+4.
REQ-033 req2: a=0xFFFFFF, b=0x000001 -> c1=0, INC carry=1, resp_sum=0x1000000.
REQ-034 req1: a=0x123456, b=0x654321 -> no INC, resp_sum=0x0777777, resp_valid at T+3.
REQ-035 All four req_valid held high with resp_ready=1 -> grant order 0,1,2,3,0; each req_ready is a single-cycle pulse.
REQ-036 resp_ready=0 for 5 cycles in DONE -> resp_sum and resp_id stable and no new grant; rst_n pulsed in HI -> resp_valid=0 and pointer=0, and no response for the aborted request.

Source files
------------

// File: rtl/bk_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bk_sched_pkg
//  Description : Shared constants for the Brent-Kung adder scheduler: beat and
//                adder port widths, FSM state encodings and the operand
//                interleave helper used to drive the external adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package bk_sched_pkg;

    localparam int BEAT_W    = 12;
    localparam int ADD_IN_W  = 24;
    localparam int ADD_OUT_W = 13;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LO   = 3'd1;
    localparam state_t ST_HI   = 3'd2;
    localparam state_t ST_INC  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // The adder expects operand bits interleaved: bit 2k = a[k], 2k+1 = b[k].
    function automatic logic [ADD_IN_W-1:0] interleave(
        input logic [BEAT_W-1:0] a,
        input logic [BEAT_W-1:0] b
    );
        logic [ADD_IN_W-1:0] r;
        r = '0;
        for (int k = 0; k < BEAT_W; k++) begin
            r[2*k]   = a[k];
            r[2*k+1] = b[k];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb
//  Description : Combinational round-robin arbiter. Searches the request
//                vector starting at the pointer and returns the first
//                requester found as a one-hot grant plus its index.
//  Ports       : i_req   - request vector
//                i_ptr   - search start position (0..NREQ-1)
//                o_grant - one-hot grant (zero when no request)
//                o_idx   - index of the granted requester
//                o_any   - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW:0]   w_pos;
    logic [IDW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // One extra bit so ptr + k cannot overflow before the wrap.
            w_pos = {1'b0, i_ptr} + (IDW+1)'(k);
            if (w_pos >= (IDW+1)'(NREQ)) begin
                w_pos = w_pos - (IDW+1)'(NREQ);
            end
            w_idx = w_pos[IDW-1:0];
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bk_add_sched.sv
`default_nettype none
// ============================================================================
//  Module      : bk_add_sched
//  Description : Time-multiplexes one external 12-bit Brent-Kung adder among
//                NREQ requesters. A granted 24-bit add runs as a low beat, a
//                high beat and, when the low beat carried out, an increment
//                beat that folds that carry into the high half.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                req_valid/req_ready   - per-requester request handshake
//                req_a, req_b          - packed operands, slice i = [i*W +: W]
//                add_in / add_out      - interleaved operands to / result from
//                                        the shared adder
//                resp_valid/resp_ready - response handshake
//                resp_id, resp_sum     - served requester and W+1 bit sum
//  Revision    : 1.0 - initial release
// ============================================================================
module bk_add_sched
    import bk_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    output logic [ADD_IN_W-1:0]      add_in,
    input  logic [ADD_OUT_W-1:0]     add_out,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [W:0]               resp_sum
);

    localparam int IDW = $clog2(NREQ);

    state_t              state_q, state_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [BEAT_W-1:0]   sum_lo_q, sum_lo_d;
    logic [BEAT_W-1:0]   sum_hi_q, sum_hi_d;
    logic                c0_q, c0_d;
    logic                c1_q, c1_d;

    logic [NREQ-1:0]     arb_grant;
    logic [IDW-1:0]      arb_idx;
    logic                arb_any;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .i_req   (req_valid),
        .i_ptr   (ptr_q),
        .o_grant (arb_grant),
        .o_idx   (arb_idx),
        .o_any   (arb_any)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        sum_lo_d   = sum_lo_q;
        sum_hi_d   = sum_hi_q;
        c0_d       = c0_q;
        c1_d       = c1_q;
        req_ready  = '0;
        add_in     = '0;
        resp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    a_d       = req_a[arb_idx*W +: W];
                    b_d       = req_b[arb_idx*W +: W];
                    id_d      = arb_idx;
                    ptr_d     = (arb_idx == IDW'(NREQ-1)) ? '0 : arb_idx + IDW'(1);
                    state_d   = ST_LO;
                end
            end
            ST_LO: begin
                add_in   = interleave(a_q[0 +: BEAT_W], b_q[0 +: BEAT_W]);
                sum_lo_d = add_out[BEAT_W-1:0];
                c0_d     = add_out[BEAT_W];
                state_d  = ST_HI;
            end
            ST_HI: begin
                add_in   = interleave(a_q[BEAT_W +: BEAT_W], b_q[BEAT_W +: BEAT_W]);
                sum_hi_d = add_out[BEAT_W-1:0];
                c1_d     = add_out[BEAT_W];
                state_d  = c0_q ? ST_INC : ST_DONE;
            end
            ST_INC: begin
                // Low-beat carry is added as a separate +1 pass so the adder
                // needs no carry-in port.
                add_in   = interleave(sum_hi_q, BEAT_W'(1));
                sum_hi_d = add_out[BEAT_W-1:0];
                c1_d     = c1_q | add_out[BEAT_W];
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            ptr_q    <= '0;
            sum_lo_q <= '0;
            sum_hi_q <= '0;
            c0_q     <= 1'b0;
            c1_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            sum_lo_q <= sum_lo_d;
            sum_hi_q <= sum_hi_d;
            c0_q     <= c0_d;
            c1_q     <= c1_d;
        end
    end

    assign resp_id  = id_q;
    assign resp_sum = {c1_q, sum_hi_q, sum_lo_q};

endmodule
`default_nettype wire
